seq_serializer: RTL and testbench

Parallel-to-serial frame transmitter feeding the serial sequence detectors. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per clock, on `dout`, which drives the detector's `din` directly. Back-to-back words stream with no idle gap. The line is held at a defined idle level between frames.

---
 rtl/seq_pkg.sv | 20 ++
 rtl/seq_serializer.sv | 147 ++++++++++++++
 tb/tb_seq_serializer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Types and default constants for the serial sequence path: the
// serializer FSM state type, plus the default frame width and idle line
// level that the detector benches also use.
// -----------------------------------------------------------------------------
package seq_pkg;

  // Serializer FSM states. PARITY is reachable only when the parity bit
  // is built in.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;

  localparam int   SER_WIDTH    = 8;
  localparam logic SER_IDLE_BIT = 1'b0;

endpackage : seq_pkg

// File: rtl/seq_serializer.sv
// -----------------------------------------------------------------------------
// seq_serializer
// Parallel-to-serial frame transmitter. It accepts a WIDTH-bit word over a
// valid/ready handshake and sends it MSB first, one bit per clock, on dout.
// Words can follow each other back to back with no idle gap. Between frames
// the line is held at IDLE_BIT.
//
// Build option: define SEQ_SERIALIZER_PARITY_EN to append one even-parity
// bit (XOR of the data bits) after the LSB. The frame then lasts WIDTH+1
// clocks.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   data_in     in   [WIDTH-1:0] word to send, sampled only on a handshake
//   load_valid  in   upstream has a word
//   load_ready  out  a word is accepted this cycle (combinational)
//   dout        out  serial bit (registered)
//   dout_valid  out  dout carries a frame bit (registered)
//   busy        out  FSM is in SHIFT or PARITY (registered)
// -----------------------------------------------------------------------------
module seq_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH    = SER_WIDTH,
  parameter logic IDLE_BIT = SER_IDLE_BIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  ser_state_t       state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [CW-1:0]    bit_cnt_reg, bit_cnt_next;
  logic             dout_reg, dout_next;
  logic             dout_valid_reg, dout_valid_next;
  logic             busy_reg, busy_next;
`ifdef SEQ_SERIALIZER_PARITY_EN
  logic             parity_reg, parity_next;
`endif

  logic transfer;

  // The MSB of shift_reg is always the bit currently on dout. bit_cnt is
  // the number of data bits still to follow it, so 0 marks the last data
  // bit.
  always_comb begin
    load_ready = 1'b0;
    case (state_reg)
      IDLE:   load_ready = 1'b1;
`ifdef SEQ_SERIALIZER_PARITY_EN
      SHIFT:  load_ready = 1'b0;
`else
      SHIFT:  load_ready = (bit_cnt_reg == '0);
`endif
      PARITY: load_ready = 1'b1;
      default: load_ready = 1'b0;
    endcase
  end

  assign transfer = load_valid && load_ready;

  always_comb begin
    state_next      = state_reg;
    shift_next      = shift_reg;
    bit_cnt_next    = bit_cnt_reg;
    dout_next       = IDLE_BIT;
    dout_valid_next = 1'b0;
    busy_next       = 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
    parity_next     = parity_reg;
`endif

    if (transfer) begin
      // A new word takes priority from any state that is ready. Its MSB goes
      // out in the very next cycle.
      state_next      = SHIFT;
      shift_next      = data_in;
      bit_cnt_next    = CW'(WIDTH - 1);
      dout_next       = data_in[WIDTH-1];
      dout_valid_next = 1'b1;
      busy_next       = 1'b1;
`ifdef SEQ_SERIALIZER_PARITY_EN
      parity_next     = ^data_in;
`endif
    end else begin
      case (state_reg)
        SHIFT: begin
          if (bit_cnt_reg != '0) begin
            shift_next      = {shift_reg[WIDTH-2:0], 1'b0};
            bit_cnt_next    = bit_cnt_reg - CW'(1);
            dout_next       = shift_reg[WIDTH-2];
            dout_valid_next = 1'b1;
            busy_next       = 1'b1;
          end else begin
`ifdef SEQ_SERIALIZER_PARITY_EN
            state_next      = PARITY;
            dout_next       = parity_reg;
            dout_valid_next = 1'b1;
            busy_next       = 1'b1;
`else
            state_next      = IDLE;
`endif
          end
        end
        default: state_next = IDLE;  // IDLE, or PARITY with no new word
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      dout_reg       <= IDLE_BIT;
      dout_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
      parity_reg     <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      shift_reg      <= shift_next;
      bit_cnt_reg    <= bit_cnt_next;
      dout_reg       <= dout_next;
      dout_valid_reg <= dout_valid_next;
      busy_reg       <= busy_next;
`ifdef SEQ_SERIALIZER_PARITY_EN
      parity_reg     <= parity_next;
`endif
    end
  end

  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;
  assign busy       = busy_reg;

endmodule : seq_serializer

// File: tb/tb_seq_serializer.sv
// -----------------------------------------------------------------------------
// tb_seq_serializer
// Directed, table-driven bench for seq_serializer (WIDTH=8, IDLE_BIT=0).
// Works with or without SEQ_SERIALIZER_PARITY_EN defined.
// -----------------------------------------------------------------------------
module tb_seq_serializer;

`ifdef SEQ_SERIALIZER_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       load_valid = 1'b0;
  logic       load_ready, dout, dout_valid, busy;

  int n_cmp = 0;
  int n_err = 0;

  seq_serializer #(.WIDTH(8), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
    .load_ready(load_ready), .dout(dout), .dout_valid(dout_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected values are written out by hand: bits in MSB-first send order,
  // the even-parity bit, and how many times 1,0,0,0 shows up in the frame.
  typedef struct {
    logic [7:0] data;
    logic [7:0] bits;
    logic       par;
    int         det;
  } vec_t;

  vec_t vecs[7];

  // Sends a then b, with load_valid held from bit index raise_at of the
  // first frame. exp holds the expected 2*FL bits, left-aligned.
  task automatic stream(input string nm, input logic [7:0] a, input logic [7:0] b,
                        input int raise_at, input logic [17:0] exp);
    @(negedge clk);
    data_in = a; load_valid = 1'b1;
    @(negedge clk);
    data_in = b; load_valid = (raise_at == 0);
    for (int i = 0; i < 2*FL; i++) begin
      if (i == raise_at) load_valid = 1'b1;
      if (i == FL) load_valid = 1'b0;
      chk($sformatf("%s dout[%0d]", nm, i), dout, exp[17-i]);
      chk($sformatf("%s valid[%0d]", nm, i), dout_valid, 1'b1);
      chk($sformatf("%s ready[%0d]", nm, i), load_ready,
          (i == FL-1 || i == 2*FL-1) ? 1'b1 : 1'b0);
      $display("%s bit %0d dout=%0b ready=%0b", nm, i, dout, load_ready);
      @(negedge clk);
    end
    chk({nm, " end valid"}, dout_valid, 1'b0);
    chk({nm, " end dout"}, dout, 1'b0);
  endtask

  initial begin
    logic [3:0] hist;
    int         det;
    int         seen;
    logic       exp_bit;

    vecs[0] = '{8'hA8, 8'b1010_1000, 1'b1, 1};
    vecs[1] = '{8'h5A, 8'b0101_1010, 1'b0, 0};
    vecs[2] = '{8'h81, 8'b1000_0001, 1'b0, 1};
    vecs[3] = '{8'h00, 8'b0000_0000, 1'b0, 0};
    vecs[4] = '{8'hFF, 8'b1111_1111, 1'b0, 0};
    vecs[5] = '{8'h07, 8'b0000_0111, 1'b1, 0};
    vecs[6] = '{8'h03, 8'b0000_0011, 1'b0, 0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset dout", dout, 1'b0);
    chk("reset valid", dout_valid, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset ready", load_ready, 1'b1);
    rst = 1'b0;

    // Single frames from the table
    foreach (vecs[v]) begin
      @(negedge clk);
      data_in = vecs[v].data; load_valid = 1'b1;
      chk($sformatf("v%0d ready before load", v), load_ready, 1'b1);
      @(negedge clk);
      load_valid = 1'b0; data_in = 8'h00;
      hist = 4'b0; det = 0;
      for (int i = 0; i < FL; i++) begin
        exp_bit = (i < 8) ? vecs[v].bits[7-i] : vecs[v].par;
        chk($sformatf("v%0d dout[%0d]", v, i), dout, exp_bit);
        chk($sformatf("v%0d valid[%0d]", v, i), dout_valid, 1'b1);
        chk($sformatf("v%0d busy[%0d]", v, i), busy, 1'b1);
        chk($sformatf("v%0d ready[%0d]", v, i), load_ready, (i == FL-1) ? 1'b1 : 1'b0);
        if (i < 8) begin
          hist = {hist[2:0], dout};
          if (i >= 3 && hist == 4'b1000) det++;
        end
        @(negedge clk);
      end
      chk($sformatf("v%0d det count", v), det, vecs[v].det);
      chk($sformatf("v%0d idle dout", v), dout, 1'b0);
      chk($sformatf("v%0d idle valid", v), dout_valid, 1'b0);
      chk($sformatf("v%0d idle busy", v), busy, 1'b0);
      chk($sformatf("v%0d idle ready", v), load_ready, 1'b1);
      $display("frame %02h sent, detections=%0d", vecs[v].data, det);
    end

    // Back-to-back with load_valid held, and a late-raised load_valid
`ifdef SEQ_SERIALIZER_PARITY_EN
    stream("b2b", 8'h80, 8'h01, 0, 18'b1000_0000_1_0000_0001_1);
    stream("hold", 8'hC3, 8'h3C, 1, 18'b1100_0011_0_0011_1100_0);
`else
    stream("b2b", 8'h80, 8'h01, 0, {16'h8001, 2'b00});
    stream("hold", 8'hC3, 8'h3C, 1, {16'hC33C, 2'b00});
`endif

    // Reset on the 4th bit of 8'hFF
    @(negedge clk);
    data_in = 8'hFF; load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort 4th bit dout", dout, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort dout", dout, 1'b0);
    chk("abort valid", dout_valid, 1'b0);
    chk("abort busy", busy, 1'b0);
    chk("abort ready", load_ready, 1'b1);
    seen = 0;
    repeat (FL) begin
      @(negedge clk);
      if (dout_valid || dout) seen++;
    end
    chk("abort leftover bits", seen, 0);
    $display("abort test done, leftover=%0d", seen);

    // Reset coincident with a handshake
    @(negedge clk);
    rst = 1'b1; data_in = 8'hFF; load_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; load_valid = 1'b0;
    chk("rst+load valid", dout_valid, 1'b0);
    chk("rst+load busy", busy, 1'b0);
    @(negedge clk);
    chk("rst+load valid next", dout_valid, 1'b0);
    chk("rst+load dout next", dout, 1'b0);
    $display("reset-vs-load test done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_seq_serializer
